// File: rtl/ceespu_alu_issue.sv
// Issue/result-capture controller between operand fetch and the ceespu ALU.
// Latency: single-cycle op accepted at edge N strobes its result in cycle N+2; multiply waits for the ALU's data-ready.
// Backpressure: O_ready (combinational) drops while an op is executing or draining, or while I_flush is high.
//
// Ports:
//   I_clk, I_rst                 clock and synchronous active-high reset
//   I_valid, O_ready             upstream issue handshake (accept on I_valid && O_ready)
//   I_dataA/B, I_Cin, I_aluop,
//   I_rd                         operation fields captured on accept
//   I_flush                      abandon the in-flight operation
//   O_aluDataA/B, O_aluCin,
//   O_aluop                      registered operands held stable toward the ALU
//   I_aluResult, I_aluMultiCycle,
//   I_aluDataReady               ALU result and multi-cycle status
//   O_resultValid, O_result,
//   O_rd                         one-cycle writeback strobe with result and tag
//   O_error                      one-cycle strobe when an op is abandoned on timeout
module ceespu_alu_issue #(
    parameter int TIMEOUT = 15
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_valid,
    input  logic [31:0] I_dataA,
    input  logic [31:0] I_dataB,
    input  logic        I_Cin,
    input  logic [3:0]  I_aluop,
    input  logic [4:0]  I_rd,
    input  logic        I_flush,
    output logic        O_ready,
    output logic [31:0] O_aluDataA,
    output logic [31:0] O_aluDataB,
    output logic        O_aluCin,
    output logic [3:0]  O_aluop,
    input  logic [31:0] I_aluResult,
    input  logic        I_aluMultiCycle,
    input  logic        I_aluDataReady,
    output logic        O_resultValid,
    output logic [31:0] O_result,
    output logic [4:0]  O_rd,
    output logic        O_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // wait_cnt holds the number of cycles already spent in the current
    // state, so the op is abandoned in its TIMEOUT-th cycle there.
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic [4:0]  rd_q;
    logic        complete;
    logic        timeout;
    logic        ready;
    logic        accept;
    logic        capture;

    // State register
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output / handshake decode
    always_comb begin
        complete = (state == ST_EXEC) && (!I_aluMultiCycle || I_aluDataReady);
        // Timeout outranks completion and flush in the same cycle.
        timeout  = !I_rst && (state != ST_IDLE) && (wait_cnt == TO_LAST);
        // Ready only in IDLE or a genuinely completing EXEC cycle, so a new
        // op can follow a finishing one on the very next edge.
        ready    = !I_rst && !I_flush &&
                   ((state == ST_IDLE) || (complete && !timeout));
        accept   = I_valid && ready;
        capture  = complete && !timeout && !I_flush && !I_rst;
        O_ready  = ready;
        O_error  = timeout;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (timeout) begin
                    state_nxt = ST_IDLE;
                end else if (I_flush) begin
                    // A multiply keeps counting inside the ALU; wait for it
                    // to finish so the next multiply starts in sync.
                    state_nxt = I_aluMultiCycle ? ST_DRAIN : ST_IDLE;
                end else if (complete) begin
                    state_nxt = accept ? ST_EXEC : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (timeout || I_aluDataReady) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Wait counter: restarts on any state entry (including a back-to-back
    // re-entry of EXEC with a new op) and saturates.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            wait_cnt <= 4'd0;
        end else if ((state_nxt != state) || accept || (state_nxt == ST_IDLE)) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != 4'hF) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Operand registers and result capture
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_aluDataA    <= 32'd0;
            O_aluDataB    <= 32'd0;
            O_aluCin      <= 1'b0;
            O_aluop       <= 4'd0;
            rd_q          <= 5'd0;
            O_resultValid <= 1'b0;
            O_result      <= 32'd0;
            O_rd          <= 5'd0;
        end else begin
            if (accept) begin
                O_aluDataA <= I_dataA;
                O_aluDataB <= I_dataB;
                O_aluCin   <= I_Cin;
                O_aluop    <= I_aluop;
                rd_q       <= I_rd;
            end
            O_resultValid <= capture;
            if (capture) begin
                O_result <= I_aluResult;
                O_rd     <= rd_q;
            end
        end
    end

endmodule
